seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Programmable serial-pattern detector controller. Software/testbench loads a pattern of up to P_MAX_LEN bits, a length, an overlap/non-overlap mode and a match threshold, then arms the block.
- Counts detections on a valid-qualified serial bit stream.
- Stops automatically when the threshold is reached.
- Generalises the team's fixed 4-state Mealy detectors into one configurable, sequenced unit.

Parameters:
- P_MAX_LEN, 8, maximum pattern length in bits (>=2).
- P_LEN_W, 4, width of length field; must hold P_MAX_LEN.
- P_CNT_W, 8, width of match counter and threshold.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_cfg_valid  in  1  config write strobe.
- i_cfg_pattern  in  P_MAX_LEN  pattern; bit [len-1] is the first bit received.
- i_cfg_len  in  P_LEN_W  pattern length; legal range 1..P_MAX_LEN.
- i_cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- i_cfg_threshold  in  P_CNT_W  auto-stop count; 0 = never stop.
- o_cfg_ready  out  1  high in IDLE only.
- o_cfg_err  out  1  one-cycle pulse on a rejected config.
- i_start  in  1  arm / restart pulse.
- i_stop  in  1  abort pulse.
- i_x_valid  in  1  serial bit qualifier.
- i_x  in  1  serial data bit.
- o_busy  out  1  high in RUN.
- o_seq_detected  out  1  one-cycle registered match pulse.
- o_match_count  out  P_CNT_W  matches since last start; saturates at all-ones.
- o_threshold_hit  out  1  high in DONE.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - All outputs 0, except o_cfg_ready = 1.
  - Config registers clear to 0; cfg_loaded = 0.
  - History and fill counter clear.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - i_cfg_valid with len in 1..P_MAX_LEN: latch all cfg fields; cfg_loaded = 1.
  - i_cfg_valid with illegal len: o_cfg_err pulses the next cycle; config unchanged.
  - i_start with cfg_loaded = 1 and no i_cfg_valid in the same cycle: go to RUN.
  - i_start with i_cfg_valid in the same cycle: config is latched and the start is ignored.
  - i_start with cfg_loaded = 0: ignored.
  - i_x_valid is ignored.
- Entering RUN (from IDLE or DONE): clear o_match_count, history and fill count.
- RUN, each cycle with i_x_valid = 1:
  - cand = {hist, i_x}.
  - fill saturates at len.
  - Match when (fill+1 >= len) and cand[len-1:0] == pattern[len-1:0].
- On a match:
  - o_seq_detected = 1 in the next cycle (latency 1 from the completing bit).
  - o_match_count increments, saturating.
  - Overlap = 1: history is kept.
  - Overlap = 0: fill resets to 0, so the next match needs len fresh bits.
  - If threshold != 0 and the new count == threshold: go to DONE, with o_threshold_hit = 1 in the same cycle as o_seq_detected.
- Without a match: shift history, fill++ (saturating at len).
- i_x_valid = 0: no shift; history is held; gaps are transparent.
- RUN, i_stop: go to IDLE; history is cleared; count is retained. i_stop has priority over a same-cycle bit, which is dropped.
- RUN, i_start: ignored. i_cfg_valid: ignored (o_cfg_ready = 0, no error).
- DONE:
  - Bits are ignored; the count is held.
  - i_stop → IDLE; o_threshold_hit clears.
  - i_start → RUN (restart); i_stop has priority over a same-cycle i_start.
- len = 1: every bit equal to pattern[0] is a match, in either mode.
- o_busy = (state == RUN). o_cfg_ready = (state == IDLE). Both are registered/state-decoded.

Decomposition:
- Shared package seq_ctrl_pkg:
  - State encodings IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
  - Default parameter constants.
- Sub-module seq_match_core:
  - Contains the history shift register, fill counter and masked compare.
  - Inputs: i_clk, i_reset, clear, shift_en, i_x, pattern, len, overlap.
  - Output: combinational match.
- The top level holds the FSM, config registers, counter and output registers.

Test Plan:
- Non-overlap: pattern 4'b1001, len 4, overlap 0, thr 0, start; bits 1,0,0,1,0,0,1 → one o_seq_detected pulse, in the cycle after bit 4; count = 1.
- Overlap: same stream with overlap = 1 → pulses after bit 4 and after bit 7; count = 2.
- Threshold: pattern 2'b11, len 2, overlap 1, thr 3; bits 1,1,1,1,1 → pulses after bits 2, 3 and 4; o_threshold_hit = 1 with the third pulse; state DONE; bit 5 ignored; count stays 3.
- Config errors: len = 0, then len = 9 (with P_MAX_LEN = 8) → o_cfg_err pulses each time; a following start with no valid config leaves o_busy = 0.
- Stop vs bit: in RUN with pattern 1001 after bits 1,0,0, assert i_stop together with i_x_valid, i_x = 1 → no detection; IDLE; count = 0 retained.
- Reset mid-run: assert i_reset asynchronously between clock edges in RUN with count = 2 → outputs zero immediately; o_cfg_ready = 1; a start after reset is ignored until a new config is loaded.

Source files
------------

// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and defaults for the programmable serial-pattern detector.
// Imported by the interface, the match core and the controller top.
package seq_ctrl_pkg;

  localparam int P_MAX_LEN_DEF = 8;
  localparam int P_LEN_W_DEF   = 4;
  localparam int P_CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Config, control, serial-stream and status bundle of seq_detect_ctrl.
// master drives config/control/stream; slave is the detector.
interface seq_detect_ctrl_if
  import seq_ctrl_pkg::*;
#(
  parameter int P_MAX_LEN = P_MAX_LEN_DEF,
  parameter int P_LEN_W   = P_LEN_W_DEF,
  parameter int P_CNT_W   = P_CNT_W_DEF
);

  logic                 i_cfg_valid;
  logic [P_MAX_LEN-1:0] i_cfg_pattern;
  logic [P_LEN_W-1:0]   i_cfg_len;
  logic                 i_cfg_overlap;
  logic [P_CNT_W-1:0]   i_cfg_threshold;
  logic                 o_cfg_ready;
  logic                 o_cfg_err;

  logic                 i_start;
  logic                 i_stop;
  logic                 i_x_valid;
  logic                 i_x;

  logic                 o_busy;
  logic                 o_seq_detected;
  logic [P_CNT_W-1:0]   o_match_count;
  logic                 o_threshold_hit;

  modport master (
    output i_cfg_valid,
    output i_cfg_pattern,
    output i_cfg_len,
    output i_cfg_overlap,
    output i_cfg_threshold,
    output i_start,
    output i_stop,
    output i_x_valid,
    output i_x,
    input  o_cfg_ready,
    input  o_cfg_err,
    input  o_busy,
    input  o_seq_detected,
    input  o_match_count,
    input  o_threshold_hit
  );

  modport slave (
    input  i_cfg_valid,
    input  i_cfg_pattern,
    input  i_cfg_len,
    input  i_cfg_overlap,
    input  i_cfg_threshold,
    input  i_start,
    input  i_stop,
    input  i_x_valid,
    input  i_x,
    output o_cfg_ready,
    output o_cfg_err,
    output o_busy,
    output o_seq_detected,
    output o_match_count,
    output o_threshold_hit
  );

endinterface

// File: rtl/seq_detect_ctrl_match.sv
// History shift register, fill counter and length-masked pattern compare.
// o_match is combinational on the bit being shifted in this cycle.
module seq_match_core
  import seq_ctrl_pkg::*;
#(
  parameter int P_MAX_LEN = P_MAX_LEN_DEF,
  parameter int P_LEN_W   = P_LEN_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_shift_en,
  input  logic                 i_x,
  input  logic [P_MAX_LEN-1:0] i_pattern,
  input  logic [P_LEN_W-1:0]   i_len,
  input  logic                 i_overlap,
  output logic                 o_match
);

  logic [P_MAX_LEN-2:0] hist_q, hist_d;
  logic [P_LEN_W-1:0]   fill_q, fill_d;
  logic [P_MAX_LEN-1:0] cand;
  logic [P_MAX_LEN-1:0] mask;
  logic [P_LEN_W:0]     fill_nx;
  logic [P_LEN_W:0]     len_x;
  logic                 full;

  always_comb begin
    mask = '0;
    for (int i = 0; i < P_MAX_LEN; i++) begin
      mask[i] = (i < int'(i_len));
    end
  end

  assign cand    = {hist_q, i_x};
  assign fill_nx = {1'b0, fill_q} + 1'b1;
  assign len_x   = {1'b0, i_len};
  assign full    = (fill_nx >= len_x);

  assign o_match = i_shift_en && full &&
                   (((cand ^ i_pattern) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (i_clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (i_shift_en) begin
      hist_d = cand[P_MAX_LEN-2:0];
      // Non-overlap: forget the used bits so the next hit needs len fresh ones
      if (o_match && !i_overlap) begin
        fill_d = '0;
      end else if (full) begin
        fill_d = i_len;
      end else begin
        fill_d = fill_nx[P_LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequencer for the programmable pattern detector: config, FSM, counter.
// The match core only sees bits while the FSM is in RUN.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int P_MAX_LEN = P_MAX_LEN_DEF,
  parameter int P_LEN_W   = P_LEN_W_DEF,
  parameter int P_CNT_W   = P_CNT_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  seq_detect_ctrl_if.slave   bus
);

  localparam logic [P_LEN_W-1:0] LEN_MAX = P_LEN_W'(P_MAX_LEN);

  state_e               state_q, state_d;
  logic [P_MAX_LEN-1:0] pat_q, pat_d;
  logic [P_LEN_W-1:0]   len_q, len_d;
  logic                 ovl_q, ovl_d;
  logic [P_CNT_W-1:0]   thr_q, thr_d;
  logic                 loaded_q, loaded_d;
  logic [P_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 det_q, det_d;
  logic                 err_q, err_d;

  logic                 clear;
  logic                 shift_en;
  logic                 match;
  logic                 cfg_legal;
  logic [P_CNT_W-1:0]   cnt_inc;

  // i_stop wins over a same-cycle bit, so the bit never reaches the core
  assign shift_en  = (state_q == RUN) && !bus.i_stop && bus.i_x_valid;
  assign cfg_legal = (bus.i_cfg_len != '0) && (bus.i_cfg_len <= LEN_MAX);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  seq_match_core #(
    .P_MAX_LEN (P_MAX_LEN),
    .P_LEN_W   (P_LEN_W)
  ) u_core (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (clear),
    .i_shift_en (shift_en),
    .i_x        (bus.i_x),
    .i_pattern  (pat_q),
    .i_len      (len_q),
    .i_overlap  (ovl_q),
    .o_match    (match)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    thr_d    = thr_q;
    loaded_d = loaded_q;
    cnt_d    = cnt_q;
    det_d    = 1'b0;
    err_d    = 1'b0;
    clear    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_cfg_valid) begin
          if (cfg_legal) begin
            pat_d    = bus.i_cfg_pattern;
            len_d    = bus.i_cfg_len;
            ovl_d    = bus.i_cfg_overlap;
            thr_d    = bus.i_cfg_threshold;
            loaded_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.i_start && loaded_q) begin
          state_d = RUN;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (bus.i_stop) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (match) begin
          det_d = 1'b1;
          cnt_d = cnt_inc;
          if (thr_q != '0 && cnt_inc == thr_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.i_stop) begin
          state_d = IDLE;
        end else if (bus.i_start) begin
          state_d = RUN;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      thr_q    <= '0;
      loaded_q <= 1'b0;
      cnt_q    <= '0;
      det_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      thr_q    <= thr_d;
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
      det_q    <= det_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_cfg_ready     = (state_q == IDLE);
  assign bus.o_busy          = (state_q == RUN);
  assign bus.o_threshold_hit = (state_q == DONE);
  assign bus.o_seq_detected  = det_q;
  assign bus.o_cfg_err       = err_q;
  assign bus.o_match_count   = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: behavioural model compared every
// cycle, plus literal expectations for the documented scenarios.
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  seq_detect_ctrl_if bus ();

  seq_detect_ctrl dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_mode;
  bit     m_loaded;
  bit [7:0] m_pat;
  int     m_len;
  bit     m_ovl;
  int     m_thr;
  int     m_count;
  bit     m_q[$];
  bit     exp_det;
  bit     exp_err;

  function automatic bit tail_matches();
    if (m_q.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_q[m_q.size() - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_loaded = 0; m_pat = 0; m_len = 0; m_ovl = 0;
      m_thr = 0; m_count = 0; m_q.delete(); exp_det = 0; exp_err = 0;
    end else begin
      exp_det = 0;
      exp_err = 0;
      if (m_mode == 0) begin
        if (bus.i_cfg_valid) begin
          if (bus.i_cfg_len >= 1 && bus.i_cfg_len <= 8) begin
            m_pat = bus.i_cfg_pattern; m_len = bus.i_cfg_len;
            m_ovl = bus.i_cfg_overlap; m_thr = bus.i_cfg_threshold;
            m_loaded = 1;
          end else exp_err = 1;
        end else if (bus.i_start && m_loaded) begin
          m_mode = 1; m_count = 0; m_q.delete();
        end
      end else if (m_mode == 1) begin
        if (bus.i_stop) begin
          m_mode = 0; m_q.delete();
        end else if (bus.i_x_valid) begin
          m_q.push_back(bus.i_x);
          if (m_q.size() > 8) void'(m_q.pop_front());
          if (tail_matches()) begin
            exp_det = 1;
            if (m_count < 255) m_count++;
            if (!m_ovl) m_q.delete();
            if (m_thr != 0 && m_count == m_thr) m_mode = 2;
          end
        end
      end else begin
        if (bus.i_stop) m_mode = 0;
        else if (bus.i_start) begin
          m_mode = 1; m_count = 0; m_q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("det",   bus.o_seq_detected,  exp_det);
    chk("err",   bus.o_cfg_err,       exp_err);
    chk("count", bus.o_match_count,   m_count);
    chk("busy",  bus.o_busy,          m_mode == 1);
    chk("ready", bus.o_cfg_ready,     m_mode == 0);
    chk("hit",   bus.o_threshold_hit, m_mode == 2);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.i_cfg_valid = 0; bus.i_start = 0; bus.i_stop = 0;
    bus.i_x_valid = 0; bus.i_x = 0;
  endtask

  task automatic cfg(input bit [7:0] pat, input int len, input bit ovl,
                     input int thr, input bit exp_e);
    @(posedge clk); #1;
    bus.i_cfg_valid = 1; bus.i_cfg_pattern = pat;
    bus.i_cfg_len = 4'(len); bus.i_cfg_overlap = ovl;
    bus.i_cfg_threshold = 8'(thr);
    @(posedge clk); #1;
    idle_inputs();
    chk("cfg_err_lit", bus.o_cfg_err, exp_e);
  endtask

  task automatic start_pulse(input bit exp_busy);
    @(posedge clk); #1; bus.i_start = 1;
    @(posedge clk); #1; idle_inputs();
    chk("start_busy_lit", bus.o_busy, exp_busy);
  endtask

  task automatic stop_pulse();
    @(posedge clk); #1; bus.i_stop = 1;
    @(posedge clk); #1; idle_inputs();
    chk("stop_ready_lit", bus.o_cfg_ready, 1);
  endtask

  task automatic send(input bit b, input bit exp_d);
    @(posedge clk); #1; bus.i_x_valid = 1; bus.i_x = b;
    @(posedge clk); #1; idle_inputs();
    chk("det_lit", bus.o_seq_detected, exp_d);
  endtask

  task automatic send_seq(input bit [6:0] bits, input bit [6:0] dets,
                          input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i], dets[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.i_cfg_pattern = 0; bus.i_cfg_len = 0;
    bus.i_cfg_overlap = 0; bus.i_cfg_threshold = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_ready_lit", bus.o_cfg_ready, 1);
    chk("rst_busy_lit",  bus.o_busy, 0);
    chk("rst_count_lit", bus.o_match_count, 0);

    // illegal lengths, then a start with nothing loaded
    cfg(8'h09, 0, 0, 0, 1);
    cfg(8'h09, 9, 0, 0, 1);
    start_pulse(0);

    // non-overlap 1001
    cfg(8'b1001, 4, 0, 0, 0);
    start_pulse(1);
    send_seq(7'b1001001, 7'b0001000, 7);
    chk("nonovl_count_lit", bus.o_match_count, 1);
    stop_pulse();
    chk("stop_keeps_count_lit", bus.o_match_count, 1);

    // overlap 1001
    cfg(8'b1001, 4, 1, 0, 0);
    start_pulse(1);
    send_seq(7'b1001001, 7'b0001001, 7);
    chk("ovl_count_lit", bus.o_match_count, 2);
    stop_pulse();

    // cfg and start together: start ignored
    @(posedge clk); #1;
    bus.i_cfg_valid = 1; bus.i_start = 1; bus.i_cfg_len = 4;
    @(posedge clk); #1; idle_inputs();
    chk("cfg_start_busy_lit", bus.o_busy, 0);

    // threshold 3 on pattern 11
    cfg(8'b11, 2, 1, 3, 0);
    start_pulse(1);
    send_seq(7'b0001111, 7'b0000111, 4);
    chk("thr_hit_lit",   bus.o_threshold_hit, 1);
    chk("thr_count_lit", bus.o_match_count, 3);
    chk("thr_busy_lit",  bus.o_busy, 0);
    send(1, 0);
    chk("done_hold_lit", bus.o_match_count, 3);
    start_pulse(1);
    chk("restart_count_lit", bus.o_match_count, 0);
    send_seq(7'b0000011, 7'b0000001, 2);
    stop_pulse();

    // len 1, non-overlap
    cfg(8'b1, 1, 0, 0, 0);
    start_pulse(1);
    send_seq(7'b0000101, 7'b0000101, 3);
    chk("len1_count_lit", bus.o_match_count, 2);
    stop_pulse();

    // stop beats a completing bit
    cfg(8'b1001, 4, 0, 0, 0);
    start_pulse(1);
    send_seq(7'b0000100, 7'b0000000, 3);
    @(posedge clk); #1;
    bus.i_stop = 1; bus.i_x_valid = 1; bus.i_x = 1;
    @(posedge clk); #1; idle_inputs();
    chk("stopbit_det_lit",   bus.o_seq_detected, 0);
    chk("stopbit_ready_lit", bus.o_cfg_ready, 1);
    chk("stopbit_count_lit", bus.o_match_count, 0);

    // asynchronous reset mid-run
    cfg(8'b11, 2, 1, 0, 0);
    start_pulse(1);
    send_seq(7'b0000111, 7'b0000011, 3);
    chk("pre_rst_count_lit", bus.o_match_count, 2);
    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("arst_count_lit", bus.o_match_count, 0);
    chk("arst_ready_lit", bus.o_cfg_ready, 1);
    chk("arst_busy_lit",  bus.o_busy, 0);
    chk("arst_det_lit",   bus.o_seq_detected, 0);
    @(posedge clk); #1 rst = 0;
    start_pulse(0);
    cfg(8'b11, 2, 1, 0, 0);
    start_pulse(1);
    send(1, 0);
    send(1, 1);
    stop_pulse();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
